// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern path.
//   PAT_*                 pattern codes understood by the pattern generator
//   DEBOUNCE_20MS_50MHZ   default debounce window in clocks (20 ms at 50 MHz)
//   db_state_t            per-switch debounce FSM states
package vga_pkg;

  localparam logic [1:0] PAT_HBARS = 2'd0;
  localparam logic [1:0] PAT_VBARS = 2'd1;
  localparam logic [1:0] PAT_XOR   = 2'd2;
  localparam logic [1:0] PAT_XNOR  = 2'd3;

  localparam int DEBOUNCE_20MS_50MHZ = 1000000;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_CHANGING = 1'b1
  } db_state_t;

endpackage

// File: rtl/vga_debounce.sv
// Single-bit switch conditioner: two-flop synchroniser followed by a
// STABLE/CHANGING debounce FSM with a saturating hold counter.
// Ports:
//   clock         board clock
//   reset         asynchronous active-high reset
//   raw_level     raw switch pin, asynchronous to clock (idles high)
//   stable_level  debounced level, changes only after the new level has
//                 held for DEBOUNCE_CYCLES+1 synchronised samples
module vga_debounce
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_level,
  output logic stable_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_level;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  // Synchroniser flops reset to the released (high) level so a held-down
  // switch out of reset is treated as a fresh press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta  <= 1'b1;
      sync_level <= 1'b1;
    end else begin
      sync_meta  <= raw_level;
      sync_level <= sync_meta;
    end
  end

  // Debounce FSM. The counter only advances while the synchronised level
  // disagrees with the accepted level; any agreement drops back to STABLE
  // and discards the partial count. The compare against CNT_LAST stops the
  // counter before it could wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= DB_STABLE;
      cnt          <= '0;
      stable_level <= 1'b1;
    end else begin
      case (state)
        DB_STABLE: begin
          cnt <= '0;
          if (sync_level != stable_level) begin
            state <= DB_CHANGING;
          end
        end
        DB_CHANGING: begin
          if (sync_level == stable_level) begin
            state <= DB_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            stable_level <= sync_level;
            state        <= DB_STABLE;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= DB_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_pattern_select.sv
// Pattern-select control stage for the VGA pattern generator.
// Debounces the two active-low push-switches and applies the resulting
// 2-bit code to the generator only on frame_start, so a frame is never
// drawn with two different patterns.
// Ports:
//   clock        50 MHz board clock
//   reset        asynchronous active-high reset
//   switch       raw push-switches, active-low, asynchronous
//   frame_start  one-clock pulse at vcount wrap
//   pattern_sel  frame-aligned pattern code
//   sel_changed  one-cycle pulse while pattern_sel first shows a new code
//   stable_sw    debounced switch levels, not frame-aligned
module vga_pattern_select
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] switch,
  input  logic       frame_start,
  output logic [1:0] pattern_sel,
  output logic       sel_changed,
  output logic [1:0] stable_sw
);

  logic [1:0] pending;

  for (genvar i = 0; i < 2; i++) begin : g_debounce
    vga_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clock       (clock),
      .reset       (reset),
      .raw_level   (switch[i]),
      .stable_level(stable_sw[i])
    );
  end

  // pending trails stable_sw by one clock, so a debounced change landing on
  // the same edge as frame_start is picked up at the following frame.
  // Both bits settling at different times within one frame are applied
  // together because only the snapshot at frame_start matters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending     <= 2'b11;
      pattern_sel <= PAT_XNOR;
      sel_changed <= 1'b0;
    end else begin
      pending     <= stable_sw;
      sel_changed <= 1'b0;
      if (frame_start && (pending != pattern_sel)) begin
        pattern_sel <= pending;
        sel_changed <= 1'b1;
      end
    end
  end

endmodule
